// File: rtl/store_buffer.sv
// Posted-write buffer between the memory stage and a multi-cycle data_mem.
// Stores queue in a small FIFO and retire in the background; loads bypass unless they hit a pending store.
module store_buffer #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_write_data,
    input  logic        cpu_memwrite,
    input  logic        cpu_memread,
    input  logic [3:0]  cpu_sign_mask,
    output logic [31:0] cpu_read_data,
    output logic        cpu_stall,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_write_data,
    output logic [3:0]  mem_sign_mask,
    output logic        mem_memwrite,
    output logic        mem_memread,
    input  logic [31:0] mem_read_data,
    input  logic        mem_clk_stall
);

    localparam int PTR_W = $clog2(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_DONE
    } state_t;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  sign_mask;
    } entry_t;

    entry_t             r_fifo [DEPTH];
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W:0]     r_count;
    state_t             r_state;
    state_t             w_state_nxt;
    logic               r_op_is_load;
    logic [31:0]        r_cpu_read_data;
    logic [31:0]        r_mem_addr;
    logic [31:0]        r_mem_write_data;
    logic [3:0]         r_mem_sign_mask;

    logic               w_full;
    logic               w_empty;
    logic               w_enq;
    logic               w_deq;
    logic               w_conflict;
    logic               w_issue_load;
    logic               w_issue_store;
    logic               w_load_done;
    logic [PTR_W-1:0]   w_offset;
    entry_t             w_head;
    entry_t             w_new_entry;

    assign w_full      = (r_count == (PTR_W+1)'(DEPTH));
    assign w_empty     = (r_count == '0);
    assign w_head      = r_fifo[r_rd_ptr];
    assign w_new_entry = '{addr: cpu_addr, data: cpu_write_data, sign_mask: cpu_sign_mask};

    assign w_enq         = cpu_memwrite & ~w_full & ~reset;
    assign w_deq         = (r_state == S_WAIT) & ~r_op_is_load & ~mem_clk_stall;
    assign w_load_done   = (r_state == S_WAIT) &  r_op_is_load & ~mem_clk_stall;
    assign w_issue_load  = (r_state == S_IDLE) & ~mem_clk_stall & cpu_memread & ~w_conflict;
    assign w_issue_store = (r_state == S_IDLE) & ~mem_clk_stall & ~w_issue_load & ~w_empty;

    // A load conflicts with any queued store to the same word; entry i is valid when its
    // distance from the head is below the occupancy.
    always_comb begin
        // NOTE: every variable written here gets a value before any branch, so no latch can be inferred.
        w_conflict = 1'b0;
        w_offset   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_offset = PTR_W'(i) - r_rd_ptr;
            if (({1'b0, w_offset} < r_count) && (r_fifo[i].addr[31:2] == cpu_addr[31:2])) begin
                w_conflict = 1'b1;
            end
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        mem_memread  = 1'b0;
        mem_memwrite = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (w_issue_load || w_issue_store) begin
                    w_state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                mem_memread  =  r_op_is_load;
                mem_memwrite = ~r_op_is_load;
                w_state_nxt  = S_WAIT;
            end
            S_WAIT: begin
                if (!mem_clk_stall) begin
                    w_state_nxt = r_op_is_load ? S_DONE : S_IDLE;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign cpu_stall = (cpu_memwrite & w_full) | (cpu_memread & (r_state != S_DONE));

    // NOTE: the entry array is pure storage and is deliberately not reset; r_count alone marks valid entries.
    always_ff @(posedge clk) begin
        if (w_enq) begin
            r_fifo[r_wr_ptr] <= w_new_entry;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state          <= S_IDLE;
            r_op_is_load     <= 1'b0;
            r_rd_ptr         <= '0;
            r_wr_ptr         <= '0;
            r_count          <= '0;
            r_cpu_read_data  <= '0;
            r_mem_addr       <= '0;
            r_mem_write_data <= '0;
            r_mem_sign_mask  <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_enq) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_deq) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            unique case ({w_enq, w_deq})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            // Address/data/mask are captured at issue and held until the next issue.
            if (w_issue_load) begin
                r_op_is_load     <= 1'b1;
                r_mem_addr       <= cpu_addr;
                r_mem_write_data <= cpu_write_data;
                r_mem_sign_mask  <= cpu_sign_mask;
            end else if (w_issue_store) begin
                r_op_is_load     <= 1'b0;
                r_mem_addr       <= w_head.addr;
                r_mem_write_data <= w_head.data;
                r_mem_sign_mask  <= w_head.sign_mask;
            end
            if (w_load_done) begin
                r_cpu_read_data <= mem_read_data;
            end
        end
    end

    assign cpu_read_data  = r_cpu_read_data;
    assign mem_addr       = r_mem_addr;
    assign mem_write_data = r_mem_write_data;
    assign mem_sign_mask  = r_mem_sign_mask;

endmodule

// File: tb/tb_store_buffer.sv
// Scoreboard bench for store_buffer: a small data_mem model with a fixed 1-cycle busy time,
// expected memory accesses and load results queued by the stimulus and checked by a monitor.
module tb_store_buffer;

    localparam int         DEPTH   = 4;
    localparam logic [3:0] MASK_W  = 4'b1111;
    localparam logic [3:0] MASK_SB = 4'b0001;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_write_data;
    logic        cpu_memwrite;
    logic        cpu_memread;
    logic [3:0]  cpu_sign_mask;
    logic [31:0] cpu_read_data;
    logic        cpu_stall;
    logic [31:0] mem_addr;
    logic [31:0] mem_write_data;
    logic [3:0]  mem_sign_mask;
    logic        mem_memwrite;
    logic        mem_memread;
    logic [31:0] mem_read_data;
    logic        mem_clk_stall;

    always #5 clk = ~clk;

    store_buffer #(.DEPTH(DEPTH)) dut (
        .clk            (clk),
        .reset          (reset),
        .cpu_addr       (cpu_addr),
        .cpu_write_data (cpu_write_data),
        .cpu_memwrite   (cpu_memwrite),
        .cpu_memread    (cpu_memread),
        .cpu_sign_mask  (cpu_sign_mask),
        .cpu_read_data  (cpu_read_data),
        .cpu_stall      (cpu_stall),
        .mem_addr       (mem_addr),
        .mem_write_data (mem_write_data),
        .mem_sign_mask  (mem_sign_mask),
        .mem_memwrite   (mem_memwrite),
        .mem_memread    (mem_memread),
        .mem_read_data  (mem_read_data),
        .mem_clk_stall  (mem_clk_stall)
    );

    // data_mem model: busy for one cycle after each access, writes on the access edge, reads combinationally.
    logic [31:0] mem_words [0:63];
    logic        mem_busy   = 1'b0;
    logic        force_busy = 1'b0;
    logic [31:0] rd_word;
    logic [7:0]  rd_byte;

    assign mem_clk_stall = mem_busy | force_busy;

    always @(posedge clk) begin
        mem_busy <= mem_memwrite | mem_memread;
        if (mem_memwrite) begin
            if (mem_sign_mask == MASK_SB)
                mem_words[mem_addr[7:2]][{mem_addr[1:0], 3'b000} +: 8] <= mem_write_data[7:0];
            else
                mem_words[mem_addr[7:2]] <= mem_write_data;
        end
    end

    always_comb begin
        rd_word = mem_words[mem_addr[7:2]];
        rd_byte = rd_word[{mem_addr[1:0], 3'b000} +: 8];
        if (mem_sign_mask == MASK_SB)
            mem_read_data = {{24{rd_byte[7]}}, rd_byte};
        else
            mem_read_data = rd_word;
    end

    typedef struct packed {
        logic        is_read;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  mask;
    } mem_ev_t;

    mem_ev_t     exp_mem [$];
    logic [31:0] exp_ld  [$];
    int          wr_cycles [$];
    int          n_checks   = 0;
    int          n_errors   = 0;
    int          cyc        = 0;
    int          mem_events = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic mem_ev_t ev(input logic r, input logic [31:0] a, input logic [31:0] d,
                                   input logic [3:0] m);
        ev.is_read = r;
        ev.addr    = a;
        ev.data    = d;
        ev.mask    = m;
    endfunction

    task automatic exp_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
        exp_mem.push_back(ev(1'b0, a, d, m));
    endtask

    task automatic exp_rd(input logic [31:0] a, input logic [3:0] m);
        exp_mem.push_back(ev(1'b1, a, 32'h0, m));
    endtask

    // Monitor: compares every memory access pulse and every completed load against the queues.
    always @(negedge clk) begin : monitor
        mem_ev_t e;
        if (!reset) begin
            if (mem_memwrite || mem_memread) begin
                mem_events++;
                if (mem_memwrite) wr_cycles.push_back(cyc);
                if (exp_mem.size() == 0) begin
                    check("unexpected_mem_access", 32'(mem_addr), 32'hFFFF_FFFF);
                end else begin
                    e = exp_mem.pop_front();
                    check("mem_kind", 32'(mem_memread), 32'(e.is_read));
                    check("mem_addr", mem_addr, e.addr);
                    check("mem_mask", 32'(mem_sign_mask), 32'(e.mask));
                    if (!e.is_read) check("mem_wdata", mem_write_data, e.data);
                end
            end
            if (cpu_memread && !cpu_stall) begin
                if (exp_ld.size() == 0)
                    check("unexpected_load_done", cpu_read_data, 32'hFFFF_FFFF);
                else
                    check("load_data", cpu_read_data, exp_ld.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m,
                            output int stalls);
        cpu_addr       = a;
        cpu_write_data = d;
        cpu_sign_mask  = m;
        cpu_memwrite   = 1'b1;
        stalls         = 0;
        @(negedge clk);
        while (cpu_stall && stalls < 100) begin
            stalls++;
            @(negedge clk);
        end
        if (cpu_stall) check("store_timeout", 32'(stalls), 32'd0);
        tick();
        cpu_memwrite = 1'b0;
    endtask

    task automatic do_load(input logic [31:0] a, input logic [3:0] m, output int stalls);
        cpu_addr      = a;
        cpu_sign_mask = m;
        cpu_memread   = 1'b1;
        stalls        = 0;
        @(negedge clk);
        while (cpu_stall && stalls < 100) begin
            stalls++;
            @(negedge clk);
        end
        if (cpu_stall) check("load_timeout", 32'(stalls), 32'd0);
        tick();
        cpu_memread = 1'b0;
    endtask

    task automatic wait_drain();
        int n = 0;
        while (exp_mem.size() != 0 && n < 200) begin
            tick();
            n++;
        end
        check("drain_pending", 32'(exp_mem.size()), 32'd0);
        repeat (4) tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int st;
        int ev0;
        for (int i = 0; i < 64; i++) mem_words[i] = 32'h0;
        mem_words[32'h80 >> 2] = 32'h0000_DEAD;
        reset          = 1'b1;
        cpu_addr       = '0;
        cpu_write_data = '0;
        cpu_memwrite   = 1'b0;
        cpu_memread    = 1'b0;
        cpu_sign_mask  = '0;
        repeat (3) tick();

        // Reset state
        @(negedge clk);
        check("rst_cpu_read_data", cpu_read_data, 32'h0);
        check("rst_cpu_stall", 32'(cpu_stall), 32'd0);
        check("rst_mem_memread", 32'(mem_memread), 32'd0);
        check("rst_mem_memwrite", 32'(mem_memwrite), 32'd0);
        check("rst_mem_addr", mem_addr, 32'h0);
        check("rst_mem_write_data", mem_write_data, 32'h0);
        check("rst_mem_sign_mask", 32'(mem_sign_mask), 32'h0);
        tick();
        reset = 1'b0;

        // Three stores drain in order, one every 4 cycles, without stalling
        wr_cycles.delete();
        exp_wr(32'h10, 32'hA, MASK_W);
        exp_wr(32'h14, 32'hB, MASK_W);
        exp_wr(32'h18, 32'hC, MASK_W);
        do_store(32'h10, 32'hA, MASK_W, st); check("t1_stall0", 32'(st), 32'd0);
        do_store(32'h14, 32'hB, MASK_W, st); check("t1_stall1", 32'(st), 32'd0);
        do_store(32'h18, 32'hC, MASK_W, st); check("t1_stall2", 32'(st), 32'd0);
        wait_drain();
        check("t1_write_count", 32'(wr_cycles.size()), 32'd3);
        if (wr_cycles.size() == 3) begin
            check("t1_spacing01", 32'(wr_cycles[1] - wr_cycles[0]), 32'd4);
            check("t1_spacing12", 32'(wr_cycles[2] - wr_cycles[1]), 32'd4);
        end
        // Read back through the buffer; empty-FIFO loads stall exactly 4 cycles
        exp_rd(32'h10, MASK_W); exp_ld.push_back(32'hA);
        do_load(32'h10, MASK_W, st); check("t1_load_stall0", 32'(st), 32'd4);
        exp_rd(32'h14, MASK_W); exp_ld.push_back(32'hB);
        do_load(32'h14, MASK_W, st); check("t1_load_stall1", 32'(st), 32'd4);
        exp_rd(32'h18, MASK_W); exp_ld.push_back(32'hC);
        do_load(32'h18, MASK_W, st); check("t1_load_stall2", 32'(st), 32'd4);

        // Five back-to-back stores: the fifth waits for the first dequeue plus one cycle
        wait_drain();
        for (int i = 0; i < 5; i++) exp_wr(32'h60 + 32'(4 * i), 32'h100 + 32'(i), MASK_W);
        for (int i = 0; i < 5; i++) begin
            do_store(32'h60 + 32'(4 * i), 32'h100 + 32'(i), MASK_W, st);
            check($sformatf("t2_stall%0d", i), 32'(st), (i == 4) ? 32'd1 : 32'd0);
        end
        wait_drain();
        check("t2_hold_addr", mem_addr, 32'h70);
        check("t2_hold_wdata", mem_write_data, 32'h104);

        // Load hitting a pending store waits for it to drain
        exp_wr(32'h20, 32'h1234, MASK_W);
        exp_rd(32'h20, MASK_W);
        exp_ld.push_back(32'h1234);
        do_store(32'h20, 32'h1234, MASK_W, st);
        do_load(32'h20, MASK_W, st);
        check("t3_load_stall", 32'(st), 32'd8);

        // Non-conflicting load overtakes queued stores
        wait_drain();
        exp_wr(32'h40, 32'h40, MASK_W);
        exp_rd(32'h80, MASK_W);
        exp_wr(32'h44, 32'h44, MASK_W);
        exp_wr(32'h48, 32'h48, MASK_W);
        exp_wr(32'h4C, 32'h4C, MASK_W);
        exp_ld.push_back(32'h0000_DEAD);
        for (int i = 0; i < 4; i++) begin
            do_store(32'h40 + 32'(4 * i), 32'h40 + 32'(4 * i), MASK_W, st);
            check($sformatf("t4_stall%0d", i), 32'(st), 32'd0);
        end
        do_load(32'h80, MASK_W, st);
        check("t4_load_stall", 32'(st), 32'd5);

        // Byte store then signed byte load of the same byte
        wait_drain();
        exp_wr(32'h21, 32'hFF, MASK_SB);
        exp_rd(32'h21, MASK_SB);
        exp_ld.push_back(32'hFFFF_FFFF);
        do_store(32'h21, 32'hFF, MASK_SB, st);
        do_load(32'h21, MASK_SB, st);
        check("t5_load_stall", 32'(st), 32'd8);

        // Reset during WAIT with two stores queued: the in-flight write lands, the other is dropped
        wait_drain();
        exp_wr(32'h50, 32'h11, MASK_W);
        do_store(32'h50, 32'h11, MASK_W, st);
        do_store(32'h54, 32'h22, MASK_W, st);
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        @(negedge clk);
        check("t6_stall_after_reset", 32'(cpu_stall), 32'd0);
        check("t6_read_data_reset", cpu_read_data, 32'h0);
        check("t6_mem_addr_reset", mem_addr, 32'h0);
        ev0 = mem_events;
        repeat (8) tick();
        check("t6_fifo_empty", 32'(mem_events - ev0), 32'd0);
        check("t6_queue_after_reset", 32'(exp_mem.size()), 32'd0);

        force_busy = 1'b1;
        exp_rd(32'h50, MASK_W);
        exp_ld.push_back(32'h11);
        ev0 = mem_events;
        fork
            do_load(32'h50, MASK_W, st);
            begin
                repeat (5) tick();
                check("t6_no_issue_while_busy", 32'(mem_events - ev0), 32'd0);
                force_busy = 1'b0;
            end
        join
        check("t6_load_stall", 32'(st), 32'd9);
        exp_rd(32'h54, MASK_W);
        exp_ld.push_back(32'h0);
        do_load(32'h54, MASK_W, st);
        check("t6_load2_stall", 32'(st), 32'd4);

        repeat (4) tick();
        check("final_mem_queue", 32'(exp_mem.size()), 32'd0);
        check("final_load_queue", 32'(exp_ld.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/store_buffer.md
# store_buffer

Posted-write buffer between the pipeline's memory stage and `data_mem`. Stores are queued in a small FIFO and retire to the multi-cycle data memory in the background, so a store stalls the pipeline only when the FIFO is full. Loads to words with no pending store bypass the queue. Loads that hit a pending store wait until the conflicting entries have drained.

## Interface
Parameters:
- `DEPTH`, 4: FIFO entries; power of two, ≥2.

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high.
- `cpu_addr`  in  32  byte address from the memory stage.
- `cpu_write_data`  in  32  store data.
- `cpu_memwrite`  in  1  store request.
- `cpu_memread`  in  1  load request; never asserted together with `cpu_memwrite`.
- `cpu_sign_mask`  in  4  access size/sign code, passed through unchanged.
- `cpu_read_data`  out  32  load result (registered).
- `cpu_stall`  out  1  holds the pipeline; the request must stay stable while high.
- `mem_addr`, `mem_write_data`, `mem_sign_mask`  out  32/32/4  to `data_mem`.
- `mem_memwrite`, `mem_memread`  out  1  to `data_mem`; pulsed for one cycle per access.
- `mem_read_data`  in  32  from `data_mem`.
- `mem_clk_stall`  in  1  `data_mem` busy indicator.

## Operation
- FIFO entry fields: {addr[31:0], data[31:0], sign_mask[3:0]}.
- Pointers are log2(DEPTH)-bit and wrap. `count` is log2(DEPTH)+1 bits. `full` is `count==DEPTH`.
- Enqueue on the edge where `cpu_memwrite & ~full & ~reset`.
- Store stall: `cpu_stall = cpu_memwrite & full` (combinational from registered `full`).
  - A dequeue in the same cycle does not clear that cycle's stall; the store is accepted one cycle later.
- Load conflict: `conflict` = any valid entry with `entry.addr[31:2] == cpu_addr[31:2]`.
- Load stall: `cpu_stall = 1` whenever `cpu_memread` is high, except in the DONE state.
- FSM states: IDLE, ISSUE, WAIT, DONE. Register `op_is_load` records the kind of access in flight.
- IDLE: issue is permitted only when `mem_clk_stall == 0`. If permitted:
  - Priority 1: load pending and no conflict → ISSUE (load) with the cpu_* fields.
  - Priority 2: FIFO non-empty → ISSUE (store) with the head entry. This also covers a load with a conflict, which drains until the conflict clears.
  - Otherwise stay in IDLE.
- ISSUE (1 cycle): drive `mem_memread` or `mem_memwrite` = 1, together with the latched addr, data and sign_mask → WAIT.
- WAIT: `mem_memread` and `mem_memwrite` = 0. `mem_addr`, `mem_write_data` and `mem_sign_mask` are held from ISSUE, because `data_mem` samples them combinationally until completion. Leave WAIT on the first cycle with `mem_clk_stall == 0`:
  - Store: dequeue the head → IDLE.
  - Load: `cpu_read_data <= mem_read_data` → DONE.
- DONE (1 cycle): `cpu_stall = 0`, and the pipeline advances on this edge → IDLE.
- Enqueue and dequeue may occur on the same edge; `count` is then unchanged and the pointers advance independently.
- The mem_* address/data/sign_mask outputs hold their last values in IDLE.

## Timing
- Reset values: `cpu_read_data=0`, `cpu_stall` combinational (0 with no request), `mem_memread=mem_memwrite=0`, `mem_addr=mem_write_data=0`, `mem_sign_mask=0`, FIFO empty, FSM IDLE.
- Reset mid-operation discards all queued stores and any load in flight. An access already started inside `data_mem` completes on its own. Afterwards IDLE waits for `mem_clk_stall==0` before issuing.
- Store into a non-full FIFO: zero stall cycles.
- Drain: one store per 4 cycles (IDLE→ISSUE→WAIT×2→IDLE) against `data_mem`'s fixed 1-cycle busy time.
- Load, empty FIFO, request in cycle 0:
  - ISSUE in cycle 1, WAIT in cycles 2–3, DONE in cycle 4.
  - `cpu_stall` is high in cycles 0–3 and low in cycle 4; `cpu_read_data` is valid in cycle 4.
- A conflicting load adds 4 cycles per store drained ahead of it, up to and including the last conflicting entry, and may drain further entries if they are at the head.
- A store arriving while the FSM is busy enqueues normally; it does not affect the operation in flight.

## Test plan
- Reset, then 3 stores to 0x10/0x14/0x18 (data 0xA,0xB,0xC) on consecutive cycles → `cpu_stall` stays 0. Three `mem_memwrite` pulses occur 4 cycles apart in FIFO order, and the memory words read back 0xA/0xB/0xC.
- 5 back-to-back stores with DEPTH=4 → the 5th sees `cpu_stall=1` until the first dequeue plus one cycle. All 5 are written in order.
- Store 0x1234 to 0x20, then immediately load word 0x20 → the load waits for the drain. `cpu_read_data=0x1234` in DONE. There is no `mem_memread` before the `mem_memwrite` completes.
- Stores queued to 0x40..0x4C, then a load of 0x80 (preloaded 0xDEAD) → `mem_memread` issues before the remaining stores. Result 0xDEAD after 5 cycles with the FIFO otherwise idle.
- Byte store 0xFF to 0x21 (`sign_mask` byte), then a signed byte load of 0x21 → the `sign_mask` is forwarded unchanged and `cpu_read_data=0xFFFFFFFF`.
- Assert `reset` during WAIT with 2 stores queued → FIFO empty, `cpu_stall=0`, and no new issue until `mem_clk_stall` is low. Subsequent accesses are correct.
